imp_exc_seq: RTL

- Excitation sequencer directly upstream of the DAC step controller.
- Divides the system clock into the DAC step clock (DacClk) and drives the controller's count-enable and reset (DacResetn).
- Each excitation burst starts at sine phase 0 (0 V step) and ends after an integer number of sine periods, with a programmable excitation frequency.
- Sits between the measurement host logic (Start/Stop, settings) and the DAC controller.

---
 rtl/imp_exc_pkg.sv | 21 ++
 rtl/imp_clk_div_toggle.sv | 39 +++
 rtl/imp_exc_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/imp_exc_pkg.sv
// Shared types and constants for the impedance excitation sequencer.
package imp_exc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RUN    = 2'd2,
        STOP_S = 2'd3
    } state_t;

    localparam int STEP_W = 6;

    localparam logic [STEP_W-1:0] STEPS_32 = 6'd32;
    localparam logic [STEP_W-1:0] STEPS_16 = 6'd16;

    // Number of DAC steps in one sine period for the captured StepNum.
    function automatic logic [STEP_W-1:0] steps_per_period(input logic step16);
        return step16 ? STEPS_16 : STEPS_32;
    endfunction

endpackage

// File: rtl/imp_clk_div_toggle.sv
// Toggle-clock divider: tclk flips every (half_period+1) enabled Clk cycles.
// The half-period timer is a down-counter that reloads on terminal count, so
// the first enabled cycle toggles at once. Disabling clears the timer and
// parks tclk low.
module imp_clk_div_toggle #(
    parameter int DIV_W = 8
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             en,
    input  logic [DIV_W-1:0] half_period,
    output logic             tclk,
    output logic             rise_stb,
    output logic             tc
);

    logic [DIV_W-1:0] cnt;

    // tc: a toggle is due on this edge if enabled; rise_stb: that toggle goes high.
    assign tc       = (cnt == '0);
    assign rise_stb = en && tc && !tclk;

    // Half-period down-counter and toggle flop.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            cnt  <= '0;
            tclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            tclk <= 1'b0;
        end else if (tc) begin
            cnt  <= half_period;
            tclk <= ~tclk;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/imp_exc_seq.sv
// Excitation sequencer in front of the DAC step controller.
// Optional PhaseIdx output enabled by macro IMP_EXC_PHASE_MIRROR_EN.
//
// state  | meaning
// IDLE   | DAC controller held in reset, waiting for Start
// ARM    | DAC reset released, DacClk parked low for ARM_CYCLES
// RUN    | DacClk toggling, counting steps and periods
// STOP_S | last period complete, CountEnable dropped for one cycle
module imp_exc_seq
    import imp_exc_pkg::*;
#(
    parameter int DIV_W      = 8,
    parameter int PER_W      = 8,
    parameter int ARM_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Start,
    input  logic             Stop,
    input  logic [DIV_W-1:0] DivSel,
    input  logic [PER_W-1:0] NumPeriods,
    input  logic             StepNum,
    output logic             DacClk,
    output logic             CountEnable,
    output logic             DacResetn,
    output logic             Busy,
    output logic             Done,
`ifdef IMP_EXC_PHASE_MIRROR_EN
    output logic [4:0]       PhaseIdx,
`endif
    output logic [PER_W-1:0] PeriodCnt
);

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0]  ARM_LOAD = ARM_W'(ARM_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [PER_W-1:0]  PER_ONE  = PER_W'(1);

    state_t            state;
    state_t            state_nx;
    logic              done_nx;
    logic              div_en;
    logic              capture;
    logic [DIV_W-1:0]  div_q;
    logic [PER_W-1:0]  num_q;
    logic              step16_q;
    logic [ARM_W-1:0]  arm_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic              stop_pend;
    logic              ending;
    logic              rise_stb;
    logic              div_tc;

    imp_clk_div_toggle #(
        .DIV_W (DIV_W)
    ) u_dac_div (
        .Clk         (Clk),
        .Resetn      (Resetn),
        .en          (div_en),
        .half_period (div_q),
        .tclk        (DacClk),
        .rise_stb    (rise_stb),
        .tc          (div_tc)
    );

    // State register.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, divider enable and Done request. The last ARM cycle enables
    // the divider so its first toggle (step 1) lands on the ARM->RUN edge. Once
    // the final period has been counted, the rise that would start a new
    // period is suppressed and replaced by the move to STOP_S.
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        div_en   = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (Start && !Stop) begin
                    state_nx = ARM;
                    capture  = 1'b1;
                end
            end
            ARM: begin
                if (Stop) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else if (arm_cnt == '0) begin
                    state_nx = RUN;
                    div_en   = 1'b1;
                end
            end
            RUN: begin
                if (ending && div_tc && !DacClk) begin
                    state_nx = STOP_S;
                end else begin
                    div_en = 1'b1;
                end
            end
            STOP_S: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Settings capture, arm timer, step/period counting and end-of-burst flags.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            div_q     <= '0;
            num_q     <= '0;
            step16_q  <= 1'b0;
            arm_cnt   <= '0;
            step_cnt  <= '0;
            PeriodCnt <= '0;
            stop_pend <= 1'b0;
            ending    <= 1'b0;
        end else if (capture) begin
            div_q     <= DivSel;
            num_q     <= NumPeriods;
            step16_q  <= StepNum;
            arm_cnt   <= ARM_LOAD;
            step_cnt  <= '0;
            PeriodCnt <= '0;
            stop_pend <= 1'b0;
            ending    <= 1'b0;
        end else begin
            if (state == ARM && arm_cnt != '0) begin
                arm_cnt <= arm_cnt - 1'b1;
            end
            if (state == RUN && Stop) begin
                stop_pend <= 1'b1;
            end
            if (rise_stb) begin
                if ((step_cnt + STEP_ONE) == steps_per_period(step16_q)) begin
                    step_cnt <= '0;
                    if (PeriodCnt != '1) begin
                        PeriodCnt <= PeriodCnt + PER_ONE;
                    end
                    if (stop_pend || (num_q != '0 && (PeriodCnt + PER_ONE) == num_q)) begin
                        ending <= 1'b1;
                    end
                end else begin
                    step_cnt <= step_cnt + STEP_ONE;
                end
            end
        end
    end

    // Registered control outputs, decoded from the upcoming state.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            CountEnable <= 1'b0;
            DacResetn   <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            CountEnable <= (state_nx == ARM) || (state_nx == RUN);
            DacResetn   <= (state_nx != IDLE);
            Busy        <= (state_nx != IDLE);
            Done        <= done_nx;
        end
    end

`ifdef IMP_EXC_PHASE_MIRROR_EN
    // Phase mirror: a free 5-bit step count per burst, so in 16-step mode the
    // second period of each 32-step cycle reads 16..31.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            PhaseIdx <= '0;
        end else if (state_nx == IDLE || state_nx == ARM) begin
            PhaseIdx <= '0;
        end else if (rise_stb) begin
            PhaseIdx <= PhaseIdx + 5'd1;
        end
    end
`endif

endmodule
